// File: rtl/risc8_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | risc8_pkg : shared RISC8 types, instruction-size helper, defaults  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package risc8_pkg;

  localparam logic [15:0] DEFAULT_RESET_VECTOR = 16'h0000;

  typedef enum logic [7:0] {
    I_NOP  = 8'h00,
    I_LDI  = 8'h10,
    I_ADD  = 8'h20,
    I_SUB  = 8'h21,
    I_AND  = 8'h30,
    I_OR   = 8'h31,
    I_LD   = 8'h40,
    I_ST   = 8'h41,
    I_JMP  = 8'h80,
    I_BZ   = 8'h81,
    I_CALL = 8'h90,
    I_RET  = 8'h91,
    I_HALT = 8'hFF
  } e_instr;

  // Instruction size minus one, shared with control/datapath.
  typedef enum logic [1:0] {
    SZ1 = 2'd0,
    SZ2 = 2'd1,
    SZ3 = 2'd2,
    SZ4 = 2'd3
  } e_isize;

  function automatic logic [2:0] isize_bytes(input e_isize sz);
    logic [2:0] n;
    n = 3'd1;
    case (sz)
      SZ1: n = 3'd1;
      SZ2: n = 3'd2;
      SZ3: n = 3'd3;
      SZ4: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/risc8_byteq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | risc8_byteq : byte FIFO, single push, 0..4 pops/cycle, 4-byte peek |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module risc8_byteq #(
  parameter int DEPTH = 6,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic [2:0]    pop_n,
  output logic [CW-1:0] count,
  output logic [31:0]   peek
);

  // Byte 0 lives at the LSBs; every byte above count is kept at zero,
  // so the peek window reads 0 for invalid bytes without masking.
  logic [DEPTH*8-1:0] r_flat;
  logic [CW-1:0]      r_count;

  logic [DEPTH*8-1:0] w_shift;
  logic [DEPTH*8-1:0] w_ins;
  logic [CW-1:0]      w_kept;

  always_comb begin
    w_kept  = r_count - CW'(pop_n);
    w_shift = r_flat >> {pop_n, 3'b000};
    w_ins   = '0;
    if (push) begin
      w_ins = {{(DEPTH*8-8){1'b0}}, push_data} << {w_kept, 3'b000};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flat  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_flat  <= '0;
      r_count <= '0;
    end else begin
      r_flat  <= w_shift | w_ins;
      r_count <= w_kept + CW'(push);
    end
  end

  assign count = r_count;
  assign peek  = r_flat[31:0];

endmodule
`default_nettype wire

// File: rtl/risc8_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | risc8_fetch : ROM byte prefetcher feeding the instruction decoder  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module risc8_fetch
  import risc8_pkg::*;
#(
  parameter int          DEPTH        = 6,
  parameter logic [15:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output e_instr      instr,
  output logic [23:0] imm,
  output logic [2:0]  avail,
  output logic [15:0] pc,
  input  logic        consume,
  input  logic [1:0]  isize,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        err
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [15:0]   r_fptr;
  logic [15:0]   r_pc;
  logic          r_inflight;
  logic          r_err;
  logic          r_run;

  logic [CW-1:0] w_count;
  logic [31:0]   w_peek;
  logic [2:0]    w_need;
  logic [2:0]    w_pop_n;
  logic          w_legal;
  logic          w_take;
  logic          w_issue;

  always_comb begin
    avail   = (w_count > CW'(4)) ? 3'd4 : w_count[2:0];
    w_need  = isize_bytes(e_isize'(isize));
    w_legal = (avail >= w_need);
    w_take  = consume & w_legal & ~redirect;
    w_pop_n = w_take ? w_need : 3'd0;
    // Counting the in-flight byte against capacity is what rules out overflow.
    w_issue = r_run & ~redirect &
              (({1'b0, w_count} + {{CW{1'b0}}, r_inflight}) < (CW+1)'(DEPTH));
  end

  // A redirect empties the queue on the same edge the stale byte would land,
  // which is how an in-flight read is squashed.
  risc8_byteq #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_byteq (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .push      (r_inflight),
    .push_data (mem_rdata),
    .pop_n     (w_pop_n),
    .count     (w_count),
    .peek      (w_peek)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fptr     <= RESET_VECTOR;
      r_pc       <= RESET_VECTOR;
      r_inflight <= 1'b0;
      r_err      <= 1'b0;
      r_run      <= 1'b0;
    end else begin
      r_run      <= 1'b1;
      r_inflight <= w_issue;
      r_err      <= consume & ~w_legal & ~redirect;
      if (redirect) begin
        r_fptr <= redirect_pc;
        r_pc   <= redirect_pc;
      end else begin
        if (w_issue) r_fptr <= r_fptr + 16'd1;
        if (w_take)  r_pc   <= r_pc + 16'(w_need);
      end
    end
  end

  assign mem_rd   = w_issue;
  assign mem_addr = r_fptr;
  assign instr    = e_instr'(w_peek[7:0]);
  assign imm      = w_peek[31:8];
  assign pc       = r_pc;
  assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_risc8_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_risc8_fetch : scoreboard bench for risc8_fetch                  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_risc8_fetch;
  import risc8_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  e_instr      instr;
  logic [23:0] imm;
  logic [2:0]  avail;
  logic [15:0] pc;
  logic        consume = 1'b0;
  logic [1:0]  isize = 2'd0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        err;

  typedef struct {
    logic [15:0] pc;
    logic [7:0]  ins;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] addr_q[$];
  logic [15:0] exp_a;
  logic [15:0] m_pc = 16'h0000;
  int          n_vec = 0;
  int          n_bad = 0;

  risc8_fetch #(
    .DEPTH        (6),
    .RESET_VECTOR (16'h0000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .instr       (instr),
    .imm         (imm),
    .avail       (avail),
    .pc          (pc),
    .consume     (consume),
    .isize       (isize),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .err         (err)
  );

  always #5 clk = ~clk;

  // ROM contents: 00 11 22 33 44 ... at the bottom, address-scrambled above.
  function automatic logic [7:0] rom(input logic [15:0] a);
    logic [7:0] p;
    p = a[7:0] * 8'h11;
    return p ^ a[15:8];
  endfunction

  // Synchronous ROM: data presented the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= rom(mem_addr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_rd && addr_q.size() != 0) begin
      exp_a = addr_q.pop_front();
      check("fetch_addr", 32'(mem_addr), 32'(exp_a));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_avail(input logic [2:0] n);
    int k = 0;
    while (avail < n && k < 50) begin
      tick();
      k++;
    end
    if (avail < n) check("avail_timeout", 32'(avail), 32'(n));
  endtask

  // Waits for a full window, lets the queue top up, then retires one instruction.
  task automatic do_consume(input logic [1:0] sz);
    exp_t e;
    wait_avail(3'd4);
    repeat (4) tick();
    m_pc = m_pc + 16'(sz) + 16'd1;
    sb_q.push_back('{pc: m_pc, ins: rom(m_pc)});
    consume = 1'b1;
    isize   = sz;
    tick();
    consume = 1'b0;
    e = sb_q.pop_front();
    check("consume_pc", 32'(pc), 32'(e.pc));
    check("consume_instr", 32'(instr), 32'(e.ins));
    check("consume_err", 32'(err), 32'h0);
  endtask

  task automatic redirect_to(input logic [15:0] a, input logic with_consume);
    m_pc        = a;
    redirect    = 1'b1;
    redirect_pc = a;
    consume     = with_consume;
    isize       = 2'd0;
    tick();
    redirect = 1'b0;
    consume  = 1'b0;
    #1;
    check("redir_pc", 32'(pc), 32'(a));
    check("redir_avail", 32'(avail), 32'h0);
    check("redir_rd", 32'(mem_rd), 32'h1);
    check("redir_addr", 32'(mem_addr), 32'(a));
    check("redir_err", 32'(err), 32'h0);
    tick();
    tick();
    check("redir_lat_avail", 32'(avail), 32'h1);
    check("redir_lat_instr", 32'(instr), 32'(rom(a)));
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_rd", 32'(mem_rd), 32'h0);
    check("rst_addr", 32'(mem_addr), 32'h0);
    check("rst_instr", 32'(instr), 32'h0);
    check("rst_imm", 32'(imm), 32'h0);
    check("rst_avail", 32'(avail), 32'h0);
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_err", 32'(err), 32'h0);

    // Sequential fetch from the reset vector
    for (int i = 0; i < 4; i++) addr_q.push_back(16'(i));
    rst_n = 1'b1;
    wait_avail(3'd4);
    check("fill_avail", 32'(avail), 32'h4);
    check("fill_instr", 32'(instr), 32'h00);
    check("fill_imm", 32'(imm), 32'h332211);
    check("fill_pc", 32'(pc), 32'h0);
    repeat (4) tick();
    check("fill_addr_drain", 32'(addr_q.size()), 32'h0);

    // Three-byte consume from a full queue
    do_consume(2'd2);
    check("pop3_avail_drop", 32'(avail <= 3'd3), 32'h1);
    wait_avail(3'd4);
    check("pop3_refill", 32'(avail), 32'h4);

    // Remaining sizes
    do_consume(2'd0);
    do_consume(2'd1);
    do_consume(2'd3);

    // Illegal consume with a single valid byte
    redirect_to(16'h0100, 1'b0);
    consume = 1'b1;
    isize   = 2'd3;
    tick();
    consume = 1'b0;
    check("ill_err", 32'(err), 32'h1);
    check("ill_pc", 32'(pc), 32'h0100);
    check("ill_instr", 32'(instr), 32'(rom(16'h0100)));
    // Nothing popped: the single byte plus the one arriving this edge.
    check("ill_avail", 32'(avail), 32'h2);
    tick();
    check("ill_err_once", 32'(err), 32'h0);

    // Redirect during an in-flight read, with a competing consume
    redirect_to(16'h1234, 1'b1);
    wait_avail(3'd4);
    check("redir_imm", 32'(imm), 32'({rom(16'h1237), rom(16'h1236), rom(16'h1235)}));
    check("redir_pc_hold", 32'(pc), 32'h1234);

    // Fetch address wrap
    addr_q.push_back(16'hFFFE);
    addr_q.push_back(16'hFFFF);
    addr_q.push_back(16'h0000);
    addr_q.push_back(16'h0001);
    redirect_to(16'hFFFE, 1'b0);
    wait_avail(3'd4);
    check("wrap_imm", 32'(imm), 32'({rom(16'h0001), rom(16'h0000), rom(16'hFFFF)}));
    do_consume(2'd3);
    check("wrap_pc", 32'(pc), 32'h0002);
    check("wrap_addr_drain", 32'(addr_q.size()), 32'h0);

    // Asynchronous reset mid-stream
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_rd", 32'(mem_rd), 32'h0);
    check("arst_addr", 32'(mem_addr), 32'h0);
    check("arst_instr", 32'(instr), 32'h0);
    check("arst_imm", 32'(imm), 32'h0);
    check("arst_avail", 32'(avail), 32'h0);
    check("arst_pc", 32'(pc), 32'h0);
    check("arst_err", 32'(err), 32'h0);
    addr_q.push_back(16'h0000);
    addr_q.push_back(16'h0001);
    m_pc = 16'h0000;
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    check("arst_addr_drain", 32'(addr_q.size()), 32'h0);
    check("arst_release_pc", 32'(pc), 32'h0);
    check("arst_release_instr", 32'(instr), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
